store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-002 Parameter PTR_W, default 2, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sb_enq_valid  input  1  store-hit enqueue request from the D-cache.
REQ-006 sb_enq_addr  input  32  byte address of the store.
REQ-007 sb_enq_data  input  32  word-aligned store data.
REQ-008 sb_enq_byte_en  input  4  byte enables of the store.
REQ-009 sb_full  output  1  no free entry; the CPU stalls the store.
REQ-010 sb_empty  output  1  no entries held.
REQ-011 sb_drain_valid  output  1  head entry is presented for drain.
REQ-012 sb_drain_addr, sb_drain_data, sb_drain_byte_en  output  32/32/4  head entry contents.
REQ-013 sb_drain_ready  input  1  cache idle and memory port free; head is consumed this cycle.
REQ-014 ld_en  input  1  load lookup enable.
REQ-015 ld_addr  input  32  load byte address.
REQ-016 fwd_hit  output  1  all 4 bytes of the load word are supplied by the buffer.
REQ-017 fwd_data  output  32  forwarded word, valid when fwd_hit.
REQ-018 fwd_conflict  output  1  some, but not all, load-word bytes are held in the buffer; the load stalls.
REQ-019 sb_overflow  output  1  sticky error flag: an enqueue arrived while full.

Function
REQ-020 The buffer SHALL be a circular FIFO with head pointer, tail pointer and a (PTR_W+1)-bit count; both pointers wrap from DEPTH-1 to 0.
REQ-021 Enqueue SHALL write {addr, data, byte_en} at the tail on the rising edge when sb_enq_valid && !sb_full.
REQ-022 sb_full SHALL equal (count == DEPTH), registered-count based; an enqueue while full is dropped and sets sb_overflow.
REQ-023 A pop SHALL occur on the rising edge when sb_drain_valid && sb_drain_ready; the head advances by one.
REQ-024 sb_drain_valid SHALL equal !sb_empty; drain outputs are driven combinationally from the head entry.
REQ-025 There SHALL be no enqueue-to-drain bypass: an entry written at edge N is presentable from cycle N+1 at the earliest.
REQ-026 A simultaneous enqueue and pop SHALL leave count unchanged; this is legal when full (the pop frees the slot on the same edge) only if sb_full was low, i.e. full blocks enqueue regardless of a same-cycle pop.
REQ-027 Drain order SHALL be strictly FIFO; entries are never coalesced.
REQ-028 Forwarding SHALL be combinational: entries match when valid and entry addr[31:2] == ld_addr[31:2].
REQ-029 The forwarded word SHALL be built by merging matching entries byte-wise from oldest to youngest, so the youngest writer of each byte wins.
REQ-030 With covered = OR of byte_en over matching entries: fwd_hit = ld_en && covered==4'b1111; fwd_conflict = ld_en && covered!=0 && covered!=4'b1111.
REQ-031 With ld_en low or no match, fwd_hit, fwd_conflict and fwd_data SHALL all be 0.
REQ-032 The entry being popped in the current cycle SHALL still participate in forwarding for that cycle.

Reset
REQ-033 On reset_n low (asynchronous), head=0, tail=0, count=0 and sb_overflow=0 SHALL be set; sb_empty=1, sb_full=0, sb_drain_valid=0, fwd_hit=0, fwd_conflict=0.
REQ-034 Entry payload registers SHALL NOT be reset; validity derives only from pointers and count.
REQ-035 Reset during a pending drain SHALL discard all entries with no further drain output.

Structure
REQ-036 Shared package: DEPTH default, the entry struct {addr[31:0], data[31:0], byte_en[3:0]} and the byte-merge function, shared with the D-cache.
REQ-037 One sub-module, sb_fwd_merge, SHALL hold the combinational match, age-ordered merge and coverage logic; the FIFO and pointer logic stays in store_buffer.

Verification
REQ-038 Reset, then enq {0x100, 0xAABBCCDD, 4'hF} with ready=0 -> next cycle drain_valid=1 with those exact outputs, sb_empty=0.
REQ-039 Enq 4 stores, ready=0 -> sb_full=1; 5th enq -> dropped, sb_overflow=1; then ready=1 for 4 cycles -> drains in order, sb_empty=1.
REQ-040 While full, enq and ready in the same cycle -> pop occurs, enq dropped, count=3.
REQ-041 Enq {0x200, 0x11223344, 4'hF}, then {0x202, 0x0000FF00, 4'b0010}; ld 0x200 -> fwd_hit=1, fwd_data=0x1122FF44.
REQ-042 Single entry {0x300, 4'b0011}; ld 0x300 -> fwd_conflict=1, fwd_hit=0; after drain -> both 0.
REQ-043 Assert reset_n low with 3 entries mid-drain -> immediately drain_valid=0 and sb_empty=1; no drain after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared store buffer definitions, also used by the D-cache.
// Provides the default depth, the entry record and the byte-merge helper.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
  } sb_entry_t;

  // Overlay the enabled bytes of wdata onto base; disabled bytes keep base.
  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: enqueue from the D-cache, drain towards memory, and
// load-forwarding lookup.
//   master : D-cache / CPU side (drives enqueue, drain_ready, load lookup)
//   slave  : store buffer (drives status, drain head and forwarding result)
interface store_buffer_if;
  logic        sb_enq_valid;
  logic [31:0] sb_enq_addr;
  logic [31:0] sb_enq_data;
  logic [3:0]  sb_enq_byte_en;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_drain_valid;
  logic [31:0] sb_drain_addr;
  logic [31:0] sb_drain_data;
  logic [3:0]  sb_drain_byte_en;
  logic        sb_drain_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_conflict;
  logic        sb_overflow;

  modport master (
    output sb_enq_valid, sb_enq_addr, sb_enq_data, sb_enq_byte_en,
           sb_drain_ready, ld_en, ld_addr,
    input  sb_full, sb_empty, sb_drain_valid, sb_drain_addr, sb_drain_data,
           sb_drain_byte_en, fwd_hit, fwd_data, fwd_conflict, sb_overflow
  );

  modport slave (
    input  sb_enq_valid, sb_enq_addr, sb_enq_data, sb_enq_byte_en,
           sb_drain_ready, ld_en, ld_addr,
    output sb_full, sb_empty, sb_drain_valid, sb_drain_addr, sb_drain_data,
           sb_drain_byte_en, fwd_hit, fwd_data, fwd_conflict, sb_overflow
  );
endinterface

// File: rtl/store_buffer_fwd_merge.sv
// sb_fwd_merge: combinational store-to-load forwarding.
// Ports:
//   ld_en, ld_addr   : load lookup request
//   ordered          : buffer entries, index 0 = oldest
//   ordered_valid    : per-slot validity in the same age order
//   fwd_hit          : every byte of the load word is held in the buffer
//   fwd_conflict     : some but not all bytes are held
//   fwd_data         : merged word (youngest writer per byte wins)
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic             ld_en,
  input  logic [31:0]      ld_addr,
  input  sb_entry_t        ordered [DEPTH],
  input  logic [DEPTH-1:0] ordered_valid,
  output logic             fwd_hit,
  output logic             fwd_conflict,
  output logic [31:0]      fwd_data
);

  logic [31:0] merged;
  logic [3:0]  covered;

  // Walking oldest to youngest lets later matches overwrite earlier bytes.
  always_comb begin
    merged  = '0;
    covered = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ordered_valid[i] && (ordered[i].addr[31:2] == ld_addr[31:2])) begin
        merged  = byte_merge(merged, ordered[i].data, ordered[i].byte_en);
        covered = covered | ordered[i].byte_en;
      end
    end
  end

  assign fwd_hit      = ld_en && (covered == 4'hF);
  assign fwd_conflict = ld_en && (covered != 4'h0) && (covered != 4'hF);
  assign fwd_data     = ld_en ? merged : 32'h0;

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending cache stores with load forwarding.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   sb           : store_buffer_if slave (enqueue, drain, forwarding, status)
// Parameters:
//   DEPTH : number of entries (power of two, 2..16)
//   PTR_W : log2(DEPTH)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  store_buffer_if.slave  sb
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             pop_fire;

  sb_entry_t        ordered [DEPTH];
  logic [DEPTH-1:0] ordered_valid;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  // Full blocks enqueue even if a pop frees a slot on the same edge.
  assign enq_fire = sb.sb_enq_valid && !full;
  assign pop_fire = !empty && sb.sb_drain_ready;

  // Payload storage carries no reset; validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail] <= '{addr: sb.sb_enq_addr, data: sb.sb_enq_data,
                     byte_en: sb.sb_enq_byte_en};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (pop_fire) head <= head + 1'b1;
      if (enq_fire && !pop_fire)      count <= count + 1'b1;
      else if (!enq_fire && pop_fire) count <= count - 1'b1;
      if (sb.sb_enq_valid && full) overflow <= 1'b1;
    end
  end

  // Present entries to the merger in age order, oldest first.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i]       = mem[head + PTR_W'(i)];
      ordered_valid[i] = ((PTR_W+1)'(i) < count);
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
    .ld_en         (sb.ld_en),
    .ld_addr       (sb.ld_addr),
    .ordered       (ordered),
    .ordered_valid (ordered_valid),
    .fwd_hit       (sb.fwd_hit),
    .fwd_conflict  (sb.fwd_conflict),
    .fwd_data      (sb.fwd_data)
  );

  assign sb.sb_full          = full;
  assign sb.sb_empty         = empty;
  assign sb.sb_drain_valid   = !empty;
  assign sb.sb_drain_addr    = mem[head].addr;
  assign sb.sb_drain_data    = mem[head].data;
  assign sb.sb_drain_byte_en = mem[head].byte_en;
  assign sb.sb_overflow      = overflow;

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a queue model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  store_buffer_if sb_bus();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: list of pending stores, oldest first.
  sb_entry_t model_q[$];
  logic      model_ovf;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                input logic rdy, input logic le,
                                input logic [31:0] la);
    sb_bus.sb_enq_valid   = v;
    sb_bus.sb_enq_addr    = a;
    sb_bus.sb_enq_data    = d;
    sb_bus.sb_enq_byte_en = be;
    sb_bus.sb_drain_ready = rdy;
    sb_bus.ld_en          = le;
    sb_bus.ld_addr        = la;
  endtask

  // One cycle: drive just after the edge, return at the falling edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rdy, input logic le,
                      input logic [31:0] la);
    @(posedge clk);
    #1;
    apply_stimulus(v, a, d, be, rdy, le, la);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 4'h0, rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Compare process: checks outputs each falling edge, then advances the
  // model with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    logic [7:0]  eb [4];
    logic [3:0]  cov;
    logic [31:0] exp_data;
    logic        is_full;
    if (!reset_n) begin
      model_q.delete();
      model_ovf = 1'b0;
      check_output("rst_empty", 32'(sb_bus.sb_empty), 32'd1);
      check_output("rst_full", 32'(sb_bus.sb_full), 32'd0);
      check_output("rst_drain_valid", 32'(sb_bus.sb_drain_valid), 32'd0);
      check_output("rst_fwd_hit", 32'(sb_bus.fwd_hit), 32'd0);
      check_output("rst_fwd_conflict", 32'(sb_bus.fwd_conflict), 32'd0);
      check_output("rst_overflow", 32'(sb_bus.sb_overflow), 32'd0);
    end else begin
      is_full = (model_q.size() == DEPTH);
      check_output("m_empty", 32'(sb_bus.sb_empty), 32'(model_q.size() == 0));
      check_output("m_full", 32'(sb_bus.sb_full), 32'(is_full));
      check_output("m_drain_valid", 32'(sb_bus.sb_drain_valid), 32'(model_q.size() != 0));
      check_output("m_overflow", 32'(sb_bus.sb_overflow), 32'(model_ovf));
      if (model_q.size() != 0) begin
        check_output("m_drain_addr", sb_bus.sb_drain_addr, model_q[0].addr);
        check_output("m_drain_data", sb_bus.sb_drain_data, model_q[0].data);
        check_output("m_drain_be", 32'(sb_bus.sb_drain_byte_en), 32'(model_q[0].byte_en));
      end
      for (int b = 0; b < 4; b++) eb[b] = 8'h0;
      cov = 4'h0;
      foreach (model_q[i]) begin
        if (model_q[i].addr[31:2] == sb_bus.ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (model_q[i].byte_en[b]) begin
              eb[b]  = model_q[i].data[8*b +: 8];
              cov[b] = 1'b1;
            end
          end
        end
      end
      exp_data = sb_bus.ld_en ? {eb[3], eb[2], eb[1], eb[0]} : 32'h0;
      check_output("m_fwd_hit", 32'(sb_bus.fwd_hit), 32'(sb_bus.ld_en && cov == 4'hF));
      check_output("m_fwd_conflict", 32'(sb_bus.fwd_conflict),
                   32'(sb_bus.ld_en && cov != 4'h0 && cov != 4'hF));
      check_output("m_fwd_data", sb_bus.fwd_data, exp_data);
      if (sb_bus.sb_enq_valid && is_full) model_ovf = 1'b1;
      if (model_q.size() != 0 && sb_bus.sb_drain_ready) void'(model_q.pop_front());
      if (sb_bus.sb_enq_valid && !is_full)
        model_q.push_back('{addr: sb_bus.sb_enq_addr, data: sb_bus.sb_enq_data,
                            byte_en: sb_bus.sb_enq_byte_en});
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    model_ovf = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    do_reset();

    // Single store, no bypass, then visible at the head.
    step(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0);
    check_output("no_bypass_empty", 32'(sb_bus.sb_empty), 32'd1);
    idle(1'b0);
    check_output("d1_valid", 32'(sb_bus.sb_drain_valid), 32'd1);
    check_output("d1_addr", sb_bus.sb_drain_addr, 32'h100);
    check_output("d1_data", sb_bus.sb_drain_data, 32'hAABBCCDD);
    check_output("d1_be", 32'(sb_bus.sb_drain_byte_en), 32'hF);
    check_output("d1_empty", 32'(sb_bus.sb_empty), 32'd0);
    idle(1'b1);
    idle(1'b0);
    check_output("d1_drained", 32'(sb_bus.sb_empty), 32'd1);

    // Fill, overflow, ordered drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h10 + 32'(4*i), 32'hD0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h99, 32'h99, 4'hF, 1'b0, 1'b0, 32'h0);
    check_output("fill_full", 32'(sb_bus.sb_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check_output("ovf_set", 32'(sb_bus.sb_overflow), 32'd1);
      check_output("order_addr", sb_bus.sb_drain_addr, 32'h10 + 32'(4*i));
    end
    idle(1'b0);
    check_output("fill_drained", 32'(sb_bus.sb_empty), 32'd1);

    // Enqueue and pop while full: pop wins, enqueue dropped.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h20 + 32'(4*i), 32'hE0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h77, 32'h77, 4'hF, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    check_output("fullpop_full", 32'(sb_bus.sb_full), 32'd0);
    check_output("fullpop_head", sb_bus.sb_drain_addr, 32'h24);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check_output("fullpop_count3", 32'(sb_bus.sb_empty), 32'd1);

    // Youngest-writer merge for a full hit.
    do_reset();
    step(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h202, 32'h0000FF00, 4'b0010, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h200);
    check_output("merge_hit", 32'(sb_bus.fwd_hit), 32'd1);
    check_output("merge_data", sb_bus.fwd_data, 32'h1122FF44);
    check_output("merge_conflict", 32'(sb_bus.fwd_conflict), 32'd0);

    // Partial coverage, including the cycle the entry is popped.
    do_reset();
    step(1'b1, 32'h300, 32'h5566_7788, 4'b0011, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h300);
    check_output("part_conflict", 32'(sb_bus.fwd_conflict), 32'd1);
    check_output("part_hit", 32'(sb_bus.fwd_hit), 32'd0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300);
    check_output("pop_still_fwd", 32'(sb_bus.fwd_conflict), 32'd1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h300);
    check_output("after_drain_conf", 32'(sb_bus.fwd_conflict), 32'd0);
    check_output("after_drain_hit", 32'(sb_bus.fwd_hit), 32'd0);
    check_output("after_drain_data", sb_bus.fwd_data, 32'h0);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h40 + 32'(4*i), 32'hF0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_valid", 32'(sb_bus.sb_drain_valid), 32'd0);
    check_output("async_empty", 32'(sb_bus.sb_empty), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    check_output("post_rst_valid", 32'(sb_bus.sb_drain_valid), 32'd0);

    // Random traffic on a narrow address window to exercise forwarding.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)),
           32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) != 0),
           32'h400 + 32'($urandom_range(0, 3) * 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
